// File: rtl/if_id_latch.sv
// IF/ID pipeline register: captures the fetched instruction and PC+4,
// supports stall (hold) and flush (bubble), tracks a valid bit and keeps
// three wrapping debug counters (fetches latched, stall cycles, flushes).
module if_id_latch #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CNT_W    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clk_en,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_pc_plus_4,
  input  logic [DATA_W-1:0] i_instruction,
  input  logic              i_cnt_clear,
  output logic [DATA_W-1:0] o_pc_plus_4,
  output logic [DATA_W-1:0] o_instruction,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_fetch_cnt,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  // Counters wrap modulo 2^CNT_W; no saturation.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] pc_plus_4_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  fetch_cnt_p1;
  logic [CNT_W-1:0]  stall_cnt_p1;
  logic [CNT_W-1:0]  flush_cnt_p1;

  // Flush beats stall, so a simultaneous stall never counts and never holds.
  logic do_flush;
  logic do_stall;
  logic do_load;

  assign do_flush = i_flush;
  assign do_stall = i_stall && !i_flush;
  assign do_load  = !i_stall && !i_flush;

  // ---- IF -> ID boundary: instruction, PC+4 and valid bit ----
  // Datapath register: reset > clock-enable freeze > flush > stall > load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      instr_p1     <= NOP_WORD;
      pc_plus_4_p1 <= '0;
      vld_p1       <= 1'b0;
    end else if (i_clk_en) begin
      if (do_flush) begin
        instr_p1     <= NOP_WORD;
        pc_plus_4_p1 <= '0;
        vld_p1       <= 1'b0;
      end else if (do_load) begin
        instr_p1     <= i_instruction;
        pc_plus_4_p1 <= i_pc_plus_4;
        vld_p1       <= 1'b1;
      end
    end
  end

  // Debug counters: a clear wins over any increment, but only when enabled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_cnt_p1 <= '0;
      stall_cnt_p1 <= '0;
      flush_cnt_p1 <= '0;
    end else if (i_clk_en) begin
      if (i_cnt_clear) begin
        fetch_cnt_p1 <= '0;
        stall_cnt_p1 <= '0;
        flush_cnt_p1 <= '0;
      end else begin
        if (do_load)  fetch_cnt_p1 <= cnt_inc(fetch_cnt_p1);
        if (do_stall) stall_cnt_p1 <= cnt_inc(stall_cnt_p1);
        if (do_flush) flush_cnt_p1 <= cnt_inc(flush_cnt_p1);
      end
    end
  end

  // Outputs come straight from registers; o_instruction also feeds the
  // fetch stage's jump-target logic, so it must stay glitch-free.
  assign o_instruction = instr_p1;
  assign o_pc_plus_4   = pc_plus_4_p1;
  assign o_valid       = vld_p1;
  assign o_fetch_cnt   = fetch_cnt_p1;
  assign o_stall_cnt   = stall_cnt_p1;
  assign o_flush_cnt   = flush_cnt_p1;

endmodule
